// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the pipelined adder/subtractor.
//   MODE_ADD / MODE_SUB : encodings of the 'sub' operation select
//   chunk_width()       : per-stage chunk width for a WIDTH/STAGES geometry
//   geometry_ok()       : legality of a WIDTH/STAGES pair, used at elaboration
// -----------------------------------------------------------------------------
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

    function automatic bit geometry_ok(input int unsigned width,
                                       input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
// Combinational CW-bit adder slice used by one pipeline stage.
//   a_c, b_c  : chunk operands (b_c already inverted for subtraction)
//   c_in      : carry into the chunk LSB
//   s_c       : chunk sum
//   c_out     : carry out of the chunk MSB
//   c_msb_in  : carry into the chunk MSB (feeds signed-overflow detection)
// -----------------------------------------------------------------------------
module addsub_chunk #(
    parameter int unsigned CW = 4
) (
    input  logic [CW-1:0] a_c,
    input  logic [CW-1:0] b_c,
    input  logic          c_in,
    output logic [CW-1:0] s_c,
    output logic          c_out,
    output logic          c_msb_in
);

    logic [CW:0] full;

    always_comb begin
        full     = {1'b0, a_c} + {1'b0, b_c} + {{CW{1'b0}}, c_in};
        s_c      = full[CW-1:0];
        c_out    = full[CW];
        // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out directly;
        // this also holds for CW == 1 where it equals c_in.
        c_msb_in = full[CW-1] ^ a_c[CW-1] ^ b_c[CW-1];
    end

endmodule

// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
// WIDTH-bit add/subtract with carry/borrow-in, split into STAGES chunks of
// CW = WIDTH/STAGES bits. The carry ripples between chunks through pipeline
// registers; latency is STAGES cycles at one beat per cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready is combinational)
//   a, b, cin, sub      : operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid/out_ready : result handshake
//   sum, cout, ovf, zero: result, carry-out (sub: 1 = no borrow),
//                         signed overflow, sum == 0
// -----------------------------------------------------------------------------
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CW = chunk_width(WIDTH, STAGES);

    if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Entry 0 is the input register; entry k+1 holds the beat after chunk k
    // has been added. Entry STAGES drives the outputs.
    logic             valid_q [0:STAGES];
    logic             valid_d [0:STAGES];
    logic             carry_q [0:STAGES];
    logic             carry_d [0:STAGES];
    logic [WIDTH-1:0] s_q     [0:STAGES];
    logic [WIDTH-1:0] s_d     [0:STAGES];
    logic [WIDTH-1:0] a_q     [0:STAGES-1];
    logic [WIDTH-1:0] a_d     [0:STAGES-1];
    logic [WIDTH-1:0] b_q     [0:STAGES-1];
    logic [WIDTH-1:0] b_d     [0:STAGES-1];
    logic             sub_q   [0:STAGES-1];
    logic             sub_d   [0:STAGES-1];
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CW-1:0]    chunk_s    [0:STAGES-1];
    logic             chunk_cout [0:STAGES-1];
    logic             chunk_cmsb [0:STAGES-1];

    logic             en;

    // Single global advance: every stage, bubbles included, moves or holds.
    assign en        = !valid_q[STAGES] || out_ready;
    assign in_ready  = en;
    assign out_valid = valid_q[STAGES];
    assign sum       = s_q[STAGES];
    assign cout      = carry_q[STAGES];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_chunk
        logic [CW-1:0] b_eff;
        assign b_eff = (sub_q[k] == MODE_SUB) ? ~b_q[k][k*CW +: CW]
                                              :  b_q[k][k*CW +: CW];
        addsub_chunk #(.CW(CW)) u_chunk (
            .a_c      (a_q[k][k*CW +: CW]),
            .b_c      (b_eff),
            .c_in     (carry_q[k]),
            .s_c      (chunk_s[k]),
            .c_out    (chunk_cout[k]),
            .c_msb_in (chunk_cmsb[k])
        );
    end

    always_comb begin
        // Subtraction is a + ~b + ~cin; fold the cin inversion into entry 0.
        valid_d[0] = in_valid;
        a_d[0]     = a;
        b_d[0]     = b;
        sub_d[0]   = sub;
        carry_d[0] = cin ^ (sub == MODE_SUB);
        s_d[0]     = '0;

        for (int unsigned k = 1; k < STAGES; k++) begin
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            sub_d[k] = sub_q[k-1];
        end

        for (int unsigned k = 0; k < STAGES; k++) begin
            valid_d[k+1]             = valid_q[k];
            carry_d[k+1]             = chunk_cout[k];
            s_d[k+1]                 = s_q[k];
            s_d[k+1][k*CW +: CW]     = chunk_s[k];
        end

        ovf_d  = chunk_cout[STAGES-1] ^ chunk_cmsb[STAGES-1];
        zero_d = (s_d[STAGES] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k <= STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                s_q[k]     <= '0;
            end
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sub_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
// Directed self-checking bench for pipelined_addsub (WIDTH=16, STAGES=4).
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated beat: accept, measure latency, check result, let it drain.
    task automatic do_beat(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                           input logic tcin, input logic tsub, input logic [15:0] es,
                           input logic ec, input logic eo, input logic ez);
        int unsigned n;
        @(negedge clk);
        in_valid = 1'b1;
        a = ta; b = tb; cin = tcin; sub = tsub;
        #1;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, 32'd4);
        check({tag, "_sum"},  {16'd0, sum},  {16'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned nb;
        int unsigned ne;
        int unsigned seen;
        int unsigned n;
        logic [15:0] hold;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        hold = '0;

        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum",       {16'd0, sum},       32'd0);
        check("rst_cout",      {31'd0, cout},      32'd0);
        check("rst_ovf",       {31'd0, ovf},       32'd0);
        check("rst_zero",      {31'd0, zero},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        do_beat("add_3_1",      16'h0003, 16'h0001, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0);
        do_beat("add_ffff_1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        do_beat("add_7fff_1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        do_beat("sub_8000_1",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        do_beat("sub_5_7",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        do_beat("sub_10_3_c1",  16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);
        do_beat("add_cin",      16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        // Streaming with a downstream stall on cycles 6..8.
        nb = 0;
        ne = 0;
        for (int cyc = 0; cyc < 40 && ne < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            in_valid  = (nb < 8);
            a   = nb[15:0];
            b   = 16'h0100;
            cin = 1'b0;
            sub = 1'b0;
            #1;
            if (cyc <= 14)
                check("stream_in_ready", {31'd0, in_ready}, (cyc >= 6 && cyc <= 8) ? 32'd0 : 32'd1);
            if (cyc == 6)
                hold = sum;
            if (cyc == 7 || cyc == 8) begin
                check("stall_sum_held", {16'd0, sum}, {16'd0, hold});
                check("stall_valid",    {31'd0, out_valid}, 32'd1);
            end
            if (out_valid && out_ready) begin
                check("stream_sum", {16'd0, sum}, 32'h0100 + ne);
                ne++;
            end
            if (in_valid && in_ready)
                nb++;
        end
        check("stream_count", ne, 32'd8);
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("stream_no_dup", seen, 32'd0);

        // Three beats in flight, the oldest stalled at the output, then reset.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 16'h0A00 + 16'(i);
            b = 16'h0001;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("inflight_valid", {31'd0, out_valid}, 32'd1);
        check("inflight_sum",   {16'd0, sum},       32'h0A01);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_sum",   {16'd0, sum},       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("post_rst_no_stale", seen, 32'd0);

        do_beat("post_rst_add", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
